// File: rtl/lemonpc_pkg.sv
// Shared defaults and the writeback entry layout used across the lemonpc core.
package lemonpc_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] rd;
        logic [DATA_WIDTH_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_if.sv
// Writeback bus: ALU and LSU request handshakes plus the register-file write port.
interface rf_writeback_if
    import lemonpc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_rd;
    logic [DATA_WIDTH-1:0] rf_data;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, rf_wen, rf_rd, rf_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, rf_wen, rf_rd, rf_data
    );
endinterface

// File: rtl/wb_fifo.sv
// Writeback queue: circular storage with head/tail/count, exposing entries in age order.
module wb_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] ent [DEPTH],
    output logic [DEPTH-1:0] occ
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_data;
    end

    // ent[0] is the head; higher indices are progressively younger.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            ent[k] = mem[head + PW'(k)];
            occ[k] = (CW'(k) < count);
        end
    end
endmodule

// File: rtl/rf_writeback.sv
// Writeback arbiter: LSU-priority intake, x0 filtering, in-order RF writes, source hazard match.
// Optional macro RF_WRITEBACK_FWD_EN adds forwarding outputs for the youngest matching entry.
module rf_writeback
    import lemonpc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rf_writeback_if.slave         wb,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  empty
`ifdef RF_WRITEBACK_FWD_EN
    ,
    output logic                  fwd1_valid,
    output logic                  fwd2_valid,
    output logic [DATA_WIDTH-1:0] fwd1_data,
    output logic [DATA_WIDTH-1:0] fwd2_data
`endif
);
    localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

    logic             full;
    logic             q_empty;
    logic             push;
    logic [EW-1:0]    push_data;
    logic [EW-1:0]    ent [DEPTH];
    logic [DEPTH-1:0] occ;
    logic             rs1_hit;
    logic             rs2_hit;

    assign wb.lsu_ready = !full;
    assign wb.alu_ready = !full && !wb.lsu_valid;

    // Requests to x0 are handshaken normally but never enqueued.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (wb.lsu_valid && wb.lsu_ready) begin
            push      = (wb.lsu_rd != '0);
            push_data = {wb.lsu_rd, wb.lsu_data};
        end else if (wb.alu_valid && wb.alu_ready) begin
            push      = (wb.alu_rd != '0);
            push_data = {wb.alu_rd, wb.alu_data};
        end
    end

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (!q_empty),
        .full      (full),
        .empty     (q_empty),
        .ent       (ent),
        .occ       (occ)
    );

    assign empty      = q_empty;
    assign wb.rf_wen  = !q_empty;
    assign wb.rf_rd   = q_empty ? '0 : ent[0][EW-1:DATA_WIDTH];
    assign wb.rf_data = q_empty ? '0 : ent[0][DATA_WIDTH-1:0];

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (occ[k] && ent[k][EW-1:DATA_WIDTH] == rs1) rs1_hit = 1'b1;
            if (occ[k] && ent[k][EW-1:DATA_WIDTH] == rs2) rs2_hit = 1'b1;
        end
    end

    assign rs1_busy = rs1_hit && (rs1 != '0);
    assign rs2_busy = rs2_hit && (rs2 != '0);

`ifdef RF_WRITEBACK_FWD_EN
    assign fwd1_valid = rs1_busy;
    assign fwd2_valid = rs2_busy;

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd1_data = '0;
        fwd2_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (occ[k] && rs1 != '0 && ent[k][EW-1:DATA_WIDTH] == rs1) fwd1_data = ent[k][DATA_WIDTH-1:0];
            if (occ[k] && rs2 != '0 && ent[k][EW-1:DATA_WIDTH] == rs2) fwd2_data = ent[k][DATA_WIDTH-1:0];
        end
    end
`endif
endmodule

// File: tb/tb_rf_writeback.sv
// Randomized bench for rf_writeback against a queue-based reference of the writeback rules.
module tb_rf_writeback;
    import lemonpc_pkg::*;

    localparam int unsigned AW    = ADDR_WIDTH_DEF;
    localparam int unsigned DW    = DATA_WIDTH_DEF;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs1, rs2;
    logic          rs1_busy, rs2_busy, empty;
`ifdef RF_WRITEBACK_FWD_EN
    logic          fwd1_valid, fwd2_valid;
    logic [DW-1:0] fwd1_data, fwd2_data;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    wb_entry_t   q[$];

    always #5 clk = ~clk;

    rf_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

    rf_writeback #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb       (wb),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .empty    (empty)
`ifdef RF_WRITEBACK_FWD_EN
        ,
        .fwd1_valid (fwd1_valid),
        .fwd2_valid (fwd2_valid),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [AW-1:0] rs);
        if (rs == 0) return 1'b0;
        foreach (q[i]) if (q[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] m_fwd(input logic [AW-1:0] rs);
        logic [DW-1:0] d = '0;
        if (rs == 0) return '0;
        foreach (q[i]) if (q[i].rd == rs) d = q[i].data;
        return d;
    endfunction

    task automatic compare();
        bit room = (q.size() < DEPTH);
        check("lsu_ready", 64'(wb.lsu_ready), 64'(room));
        check("alu_ready", 64'(wb.alu_ready), 64'(room && !wb.lsu_valid));
        check("rf_wen",    64'(wb.rf_wen),    64'(q.size() != 0));
        check("rf_rd",     64'(wb.rf_rd),     q.size() != 0 ? 64'(q[0].rd)   : 64'd0);
        check("rf_data",   64'(wb.rf_data),   q.size() != 0 ? 64'(q[0].data) : 64'd0);
        check("empty",     64'(empty),        64'(q.size() == 0));
        check("rs1_busy",  64'(rs1_busy),     64'(m_busy(rs1)));
        check("rs2_busy",  64'(rs2_busy),     64'(m_busy(rs2)));
`ifdef RF_WRITEBACK_FWD_EN
        check("fwd1_valid", 64'(fwd1_valid), 64'(m_busy(rs1)));
        check("fwd2_valid", 64'(fwd2_valid), 64'(m_busy(rs2)));
        check("fwd1_data",  64'(fwd1_data),  64'(m_fwd(rs1)));
        check("fwd2_data",  64'(fwd2_data),  64'(m_fwd(rs2)));
`endif
    endtask

    // Apply the acceptance/retire rules to the model at a clock edge.
    task automatic model_edge();
        bit        room = (q.size() < DEPTH);
        bit        take = 1'b0;
        wb_entry_t e;
        if (wb.lsu_valid && room) begin
            take = 1'b1; e.rd = wb.lsu_rd; e.data = wb.lsu_data;
        end else if (wb.alu_valid && room) begin
            take = 1'b1; e.rd = wb.alu_rd; e.data = wb.alu_data;
        end
        if (q.size() != 0) void'(q.pop_front());
        if (take && e.rd != 0) q.push_back(e);
    endtask

    task automatic cycle();
        #1 compare();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
        wb.alu_valid = av; wb.alu_rd = ard; wb.alu_data = ad;
        wb.lsu_valid = lv; wb.lsu_rd = lrd; wb.lsu_data = ld;
    endtask

    initial begin
        rst_n = 1'b0;
        rs1 = '0; rs2 = '0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cycle();
        wb.lsu_valid = 1'b1;
        cycle();
        check("rst_alu_ready_lsu_hi", 64'(wb.alu_ready), 64'd0);
        wb.lsu_valid = 1'b0;
        rst_n = 1'b1;

        // Single ALU write to x3
        drive(1, 5'd3, 32'hDEADBEEF, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1 check("alu_wen", 64'(wb.rf_wen), 64'd1);
        check("alu_rd", 64'(wb.rf_rd), 64'd3);
        check("alu_data", 64'(wb.rf_data), 64'hDEADBEEF);
        cycle();
        #1 check("alu_empty_after", 64'(empty), 64'd1);
        cycle();

        // Simultaneous requests: LSU wins, ALU follows
        drive(1, 5'd6, 32'h22, 1, 5'd5, 32'h11);
        #1 check("both_alu_ready", 64'(wb.alu_ready), 64'd0);
        cycle();
        wb.lsu_valid = 1'b0;
        #1 check("both_first_rd", 64'(wb.rf_rd), 64'd5);
        check("both_alu_ready2", 64'(wb.alu_ready), 64'd1);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1 check("both_second_rd", 64'(wb.rf_rd), 64'd6);
        check("both_second_data", 64'(wb.rf_data), 64'h22);
        cycle();

        // x0 write is swallowed
        drive(1, 5'd0, 32'h55, 0, 0, 0);
        #1 check("x0_ready", 64'(wb.alu_ready), 64'd1);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1 check("x0_wen", 64'(wb.rf_wen), 64'd0);
        check("x0_empty", 64'(empty), 64'd1);
        cycle();

        // Hazard on x7
        drive(1, 5'd7, 32'hA, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        rs1 = 5'd7; rs2 = 5'd0;
        #1 check("haz_rs1_busy", 64'(rs1_busy), 64'd1);
        check("haz_rs2_busy", 64'(rs2_busy), 64'd0);
        cycle();
        rs1 = '0;

        // Asynchronous reset while an entry is queued
        drive(1, 5'd9, 32'h99, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1 check("arst_pre_wen", 64'(wb.rf_wen), 64'd1);
        #1 rst_n = 1'b0;
        q.delete();
        #1 check("arst_wen", 64'(wb.rf_wen), 64'd0);
        compare();
        @(posedge clk);
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        cycle();
        #1 check("arst_no_write", 64'(wb.rf_wen), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)), $urandom);
            rs1 = AW'($urandom_range(0, 7));
            rs2 = AW'($urandom_range(0, 7));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
